// File: rtl/fetch_pkg.sv
// Shared constants and the IF/ID record type for the fetch stage.
// The IF/ID record is sized for up to 32-bit addresses and instruction words.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc:       32'h0000_0000,
        pc_plus4: 32'h0000_0000,
        valid:    1'b0
    };

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and a combinational memory (slave).
interface fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_instr;

    modport master (output imem_addr, input  imem_instr);
    modport slave  (input  imem_addr, output imem_instr);
endinterface

// File: rtl/pc_register.sv
// Program counter flop and next-PC selection: redirect beats stall, otherwise PC+4 (wrapping).
module pc_register #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_target_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o
);

    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_plus4_s;

    // Next-PC selection; redirect targets are forced to word alignment
    always_comb begin
        pc_plus4_s = pc_q + ADDR_WIDTH'(4);
        pc_d       = pc_plus4_s;
        if (redirect_i) begin
            pc_d = {redirect_target_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (stall_i) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus4_s;
        end
    end

    // PC state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_s;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, zero-latency imem address, IF/ID pipeline register.
// Define FETCH_PERF_CNT_EN to build in the fetch/stall/flush event counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_target_i,
    fetch_if.master               imem,
    output logic [DATA_WIDTH-1:0] id_instr_o,
    output logic [ADDR_WIDTH-1:0] id_pc_o,
    output logic [ADDR_WIDTH-1:0] id_pc_plus4_o,
    output logic                  id_valid_o,
    output logic [31:0]           perf_fetch_o,
    output logic [31:0]           perf_stall_o,
    output logic [31:0]           perf_flush_o
);

    logic [ADDR_WIDTH-1:0] pc_s;
    logic [ADDR_WIDTH-1:0] pc_plus4_s;
    logic                  bubble_s;
    logic                  hold_s;
    logic                  capture_s;
    if_id_t                if_id_d;
    if_id_t                if_id_q;

    pc_register #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_register (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .pc_o              (pc_s),
        .pc_plus4_o        (pc_plus4_s)
    );

    assign imem.imem_addr = pc_s;

    // IF/ID next value: a redirect squashes the wrong-path word even while stalled
    always_comb begin
        bubble_s  = flush_i | redirect_i;
        hold_s    = stall_i & ~bubble_s;
        capture_s = ~bubble_s & ~stall_i;
        if_id_d   = if_id_q;
        if (bubble_s) begin
            if_id_d = IF_ID_BUBBLE;
        end else if (hold_s) begin
            if_id_d = if_id_q;
        end else begin
            if_id_d.instr    = 32'(imem.imem_instr);
            if_id_d.pc       = 32'(pc_s);
            if_id_d.pc_plus4 = 32'(pc_plus4_s);
            if_id_d.valid    = 1'b1;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_id_q <= IF_ID_BUBBLE;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign id_instr_o    = DATA_WIDTH'(if_id_q.instr);
    assign id_pc_o       = ADDR_WIDTH'(if_id_q.pc);
    assign id_pc_plus4_o = ADDR_WIDTH'(if_id_q.pc_plus4);
    assign id_valid_o    = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_d;
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_d;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_d;
    logic [31:0] perf_flush_q;

    // Event counter increments; all three wrap silently at 2^32
    always_comb begin
        perf_fetch_d = perf_fetch_q + {31'd0, capture_s};
        perf_stall_d = perf_stall_q + {31'd0, hold_s};
        perf_flush_d = perf_flush_q + {31'd0, bubble_s};
    end

    // Event counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_stall_o = perf_stall_q;
    assign perf_flush_o = perf_flush_q;
`else
    logic unused_capture_s;
    assign unused_capture_s = capture_s;
    assign perf_fetch_o = 32'd0;
    assign perf_stall_o = 32'd0;
    assign perf_flush_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a combinational instruction memory model.
// Counter expectations follow FETCH_PERF_CNT_EN (zero when it is undefined).
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;
    logic        id_valid_o;
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_stall_o;
    logic [31:0] perf_flush_o;

    int tests = 0;
    int fails = 0;

    fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    fetch_stage #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (stall_i),
        .flush_i           (flush_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .imem              (bus),
        .id_instr_o        (id_instr_o),
        .id_pc_o           (id_pc_o),
        .id_pc_plus4_o     (id_pc_plus4_o),
        .id_valid_o        (id_valid_o),
        .perf_fetch_o      (perf_fetch_o),
        .perf_stall_o      (perf_stall_o),
        .perf_flush_o      (perf_flush_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0050_0093;
        return 32'hA000_0000 ^ a;
    endfunction

    assign bus.imem_instr = imem_word(bus.imem_addr);

    function automatic logic [31:0] pexp(input int v);
`ifdef FETCH_PERF_CNT_EN
        return 32'(v);
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rn, input logic st, input logic fl,
                        input logic rd, input logic [31:0] tgt);
        @(negedge clk);
        rst_n = rn; stall_i = st; flush_i = fl; redirect_i = rd; redirect_target_i = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                             input logic [31:0] instr, input logic [31:0] pc4, input logic vld,
                             input int ef, input int es, input int eb);
        chk({tag, ".pc"},       bus.imem_addr, pc);
        chk({tag, ".id_pc"},    id_pc_o, ipc);
        chk({tag, ".instr"},    id_instr_o, instr);
        chk({tag, ".pc4"},      id_pc_plus4_o, pc4);
        chk({tag, ".valid"},    {31'd0, id_valid_o}, {31'd0, vld});
        chk({tag, ".p_fetch"},  perf_fetch_o, pexp(ef));
        chk({tag, ".p_stall"},  perf_stall_o, pexp(es));
        chk({tag, ".p_flush"},  perf_flush_o, pexp(eb));
    endtask

    typedef struct {
        logic        st;
        logic        fl;
        logic        rd;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_ipc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_vld;
        int          e_f;
        int          e_s;
        int          e_b;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // stall flush redir target | pc ; id_pc ; instr ; pc+4 ; valid | fetch stall flush
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h4,        32'h0,        32'h0050_0093, 32'h4,        1'b1, 1, 0, 0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h8,        32'h4,        32'hA000_0004, 32'h8,        1'b1, 2, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h8,        32'h4,        32'hA000_0004, 32'h8,        1'b1, 2, 1, 0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h8,        32'h4,        32'hA000_0004, 32'h8,        1'b1, 2, 2, 0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h8,        32'h4,        32'hA000_0004, 32'h8,        1'b1, 2, 3, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'hC,        32'h8,        32'hA000_0008, 32'hC,        1'b1, 3, 3, 0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h10,       32'h0,        32'h0000_0013, 32'h0,        1'b0, 3, 3, 1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h10,       32'h0,        32'h0000_0013, 32'h0,        1'b0, 3, 3, 2};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h100, 32'h0,     32'h0000_0013, 32'h0,        1'b0, 3, 3, 3};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h104,      32'h100,      32'hA000_0100, 32'h104,      1'b1, 4, 3, 3};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 32'h0000_0013, 32'h0,      1'b0, 4, 3, 4};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0,        32'hFFFF_FFFC, 32'h5FFF_FFFC, 32'h0,       1'b1, 5, 3, 4};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h4,        32'h0,        32'h0050_0093, 32'h4,        1'b1, 6, 3, 4};

        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_target_i = 32'h0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_state("reset", 32'h0, 32'h0, 32'h0000_0013, 32'h0, 1'b0, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            step(1'b1, vecs[i].st, vecs[i].fl, vecs[i].rd, vecs[i].tgt);
            chk_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ipc, vecs[i].e_instr,
                      vecs[i].e_pc4, vecs[i].e_vld, vecs[i].e_f, vecs[i].e_s, vecs[i].e_b);
        end

        // Redirect to 0x40, then reset while flush/stall/redirect are all active
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
        chk("redir40.pc", bus.imem_addr, 32'h40);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0080);
        chk_state("rst_mid", 32'h0, 32'h0, 32'h0000_0013, 32'h0, 1'b0, 0, 0, 0);

        // First fetch after release comes from the reset vector
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_state("post_rst", 32'h4, 32'h0, 32'h0050_0093, 32'h4, 1'b1, 1, 0, 0);

        // Nine further straight-line fetches: ten captures since reset
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        chk_state("ten_fetch", 32'h28, 32'h24, 32'hA000_0024, 32'h28, 1'b1, 10, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
